mpsoc_sysid_checker: RTL

//  Avalon-MM read master that interrogates the system-ID slave: reads word 0 (ID) then word 1 (timestamp).

---
 rtl/mpsoc_sysid_pkg.sv | 18 +
 rtl/sysid_timeout_ctr.sv | 29 ++
 rtl/mpsoc_sysid_checker.sv | 133 +++++++++++++
 3 files changed

// File: rtl/mpsoc_sysid_pkg.sv
// rtl/mpsoc_sysid_pkg.sv - shared types and constants for the system-ID checker
package mpsoc_sysid_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ_ID,
        ST_WAIT_ID,
        ST_REQ_TS,
        ST_WAIT_TS,
        ST_FINISH
    } sysid_state_t;

    localparam logic [31:0] ID_OFFSET           = 32'd0;
    localparam logic [31:0] TS_OFFSET           = 32'd4;
    localparam logic [31:0] DEFAULT_EXPECTED_ID = 32'd1;
    localparam logic [31:0] DEFAULT_EXPECTED_TS = 32'd1715854611;

endpackage

// File: rtl/sysid_timeout_ctr.sv
// rtl/sysid_timeout_ctr.sv - per-transaction cycle counter with expiry flag
module sysid_timeout_ctr #(
    parameter int unsigned LIMIT = 1024
) (
    input  logic clock,
    input  logic reset_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int unsigned W = (LIMIT > 2) ? $clog2(LIMIT) : 1;

    logic [W-1:0] count;

    // Saturates at LIMIT-1 so the flag stays asserted until the owner clears it.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && !expired) begin
            count <= count + W'(1);
        end
    end

    assign expired = (count == W'(LIMIT - 1));

endmodule

// File: rtl/mpsoc_sysid_checker.sv
// rtl/mpsoc_sysid_checker.sv - Avalon-MM master that reads and verifies the system-ID slave
module mpsoc_sysid_checker
    import mpsoc_sysid_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
    parameter logic [31:0] EXPECTED_ID    = DEFAULT_EXPECTED_ID,
    parameter logic [31:0] EXPECTED_TS    = DEFAULT_EXPECTED_TS,
    parameter bit          CHECK_TS       = 1'b1,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    output logic [31:0] avm_address,
    output logic        avm_read,
    input  logic        avm_waitrequest,
    input  logic        avm_readdatavalid,
    input  logic [31:0] avm_readdata,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic        id_ok,
    output logic        ts_ok,
    output logic        timeout,
    output logic [31:0] id_value,
    output logic [31:0] ts_value
);

    sysid_state_t state, next_state;
    logic         tmo_clear;
    logic         tmo_expired;
    logic         id_match;
    logic         ts_match;

    assign id_match = (avm_readdata == EXPECTED_ID);
    assign ts_match = (avm_readdata == EXPECTED_TS);

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // A response arriving on the expiry edge takes priority over the timeout.
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:    if (start) next_state = ST_REQ_ID;
            ST_REQ_ID:  if (tmo_expired) next_state = ST_FINISH;
                        else if (!avm_waitrequest) next_state = ST_WAIT_ID;
            ST_WAIT_ID: if (avm_readdatavalid) next_state = CHECK_TS ? ST_REQ_TS : ST_FINISH;
                        else if (tmo_expired) next_state = ST_FINISH;
            ST_REQ_TS:  if (tmo_expired) next_state = ST_FINISH;
                        else if (!avm_waitrequest) next_state = ST_WAIT_TS;
            ST_WAIT_TS: if (avm_readdatavalid || tmo_expired) next_state = ST_FINISH;
            ST_FINISH:  next_state = ST_IDLE;
            default:    next_state = ST_IDLE;
        endcase
    end

    assign avm_read    = (state == ST_REQ_ID) || (state == ST_REQ_TS);
    assign avm_address = (state == ST_REQ_TS || state == ST_WAIT_TS) ? BASE_ADDR + TS_OFFSET
                                                                     : BASE_ADDR + ID_OFFSET;
    assign busy        = (state != ST_IDLE) && (state != ST_FINISH);
    assign done        = (state == ST_FINISH);

    // Held at zero while idle so every REQ_* entry starts from a fresh count.
    assign tmo_clear = (state == ST_IDLE) || (state == ST_WAIT_ID && next_state == ST_REQ_TS);

    sysid_timeout_ctr #(
        .LIMIT(TIMEOUT_CYCLES)
    ) u_timeout_ctr (
        .clock  (clock),
        .reset_n(reset_n),
        .clear  (tmo_clear),
        .enable (busy),
        .expired(tmo_expired)
    );

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            pass     <= 1'b0;
            id_ok    <= 1'b0;
            ts_ok    <= 1'b0;
            timeout  <= 1'b0;
            id_value <= '0;
            ts_value <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        pass     <= 1'b0;
                        id_ok    <= 1'b0;
                        ts_ok    <= 1'b0;
                        timeout  <= 1'b0;
                        id_value <= '0;
                        ts_value <= '0;
                    end
                end
                ST_REQ_ID, ST_REQ_TS: begin
                    if (tmo_expired) begin
                        timeout <= 1'b1;
                        pass    <= 1'b0;
                    end
                end
                ST_WAIT_ID: begin
                    if (avm_readdatavalid) begin
                        id_value <= avm_readdata;
                        id_ok    <= id_match;
                        if (!CHECK_TS) pass <= id_match;
                    end else if (tmo_expired) begin
                        timeout <= 1'b1;
                        pass    <= 1'b0;
                    end
                end
                ST_WAIT_TS: begin
                    if (avm_readdatavalid) begin
                        ts_value <= avm_readdata;
                        ts_ok    <= ts_match;
                        pass     <= id_ok && ts_match;
                    end else if (tmo_expired) begin
                        timeout <= 1'b1;
                        pass    <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
